inst_encoder: RTL and testbench

Assembles 32-bit RV32I instruction words from decoded fields (format, registers, funct, signed immediate). It is the inverse of the core's immediate generator: it packs immediates into the scattered I/S/B/U/J bit positions. It is used by the boot/self-test program loader to stream encoded words and their byte addresses into instruction memory. It has a valid/ready input, a one-deep registered output stage, immediate range checking and an address counter.

---
 rtl/inst_encoder.sv | 133 +++++++++++++
 tb/tb_inst_encoder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// RV32I instruction word assembler: packs decoded fields and immediates into 32-bit words with byte addresses.
// Latency 1 cycle; one-deep output register, in_ready drops while the held word is unconsumed or clear is high.
module inst_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           fmt,
    input  logic [4:0]           rd,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic [31:0]          imm,
    input  logic                 clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_inst,
    output logic [31:0]          out_addr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_LOAD = 3'd1;
    localparam logic [2:0] FMT_ALU  = 3'd2;
    localparam logic [2:0] FMT_S    = 3'd3;
    localparam logic [2:0] FMT_B    = 3'd4;
    localparam logic [2:0] FMT_U    = 3'd5;
    localparam logic [2:0] FMT_J    = 3'd6;
    localparam logic [2:0] FMT_JALR = 3'd7;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_ALU  = 7'b0010011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_U    = 7'b0110111;
    localparam logic [6:0] OP_J    = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic [31:0]  enc_inst;
    logic         imm_ok;
    logic         accept;
    logic [31:0]  addr_cnt;

    // Sign-extension checks: the bits above the encodable field must all match its top bit.
    logic sx_i;
    logic sx_b;
    logic sx_j;

    assign sx_i = (&imm[31:11]) | ~(|imm[31:11]);
    assign sx_b = (&imm[31:12]) | ~(|imm[31:12]);
    assign sx_j = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        enc_inst = 32'h0;
        imm_ok   = 1'b1;
        case (fmt)
            FMT_R: begin
                enc_inst = {funct7, rs2, rs1, funct3, rd, OP_R};
            end
            FMT_LOAD: begin
                enc_inst = {imm[11:0], rs1, funct3, rd, OP_LOAD};
                imm_ok   = sx_i;
            end
            FMT_ALU: begin
                enc_inst = {imm[11:0], rs1, funct3, rd, OP_ALU};
                imm_ok   = sx_i;
            end
            FMT_S: begin
                enc_inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_S};
                imm_ok   = sx_i;
            end
            FMT_B: begin
                enc_inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_B};
                imm_ok   = sx_b && !imm[0];
            end
            FMT_U: begin
                enc_inst = {imm[31:12], rd, OP_U};
                imm_ok   = (imm[11:0] == 12'h000);
            end
            FMT_J: begin
                enc_inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_J};
                imm_ok   = sx_j && !imm[0];
            end
            FMT_JALR: begin
                enc_inst = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
                imm_ok   = sx_i;
            end
            default: begin
                enc_inst = NOP_INST;
                imm_ok   = 1'b1;
            end
        endcase
    end

    assign in_ready = !clear && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_inst  <= 32'h0;
            out_addr  <= BASE_ADDR;
            out_err   <= 1'b0;
            err_cnt   <= '0;
            addr_cnt  <= BASE_ADDR;
        end else if (clear) begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            err_cnt   <= '0;
            addr_cnt  <= BASE_ADDR;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_inst  <= imm_ok ? enc_inst : NOP_INST;
            out_addr  <= addr_cnt;
            out_err   <= !imm_ok;
            addr_cnt  <= addr_cnt + 32'd4;
            // Errored words still consume an address slot so the image layout is preserved.
            if (!imm_ok && (err_cnt != '1))
                err_cnt <= err_cnt + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed-vector bench for inst_encoder with a queue scoreboard and an independent output monitor.
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  fmt = 3'd0;
    logic [4:0]  rd = 5'd0;
    logic [4:0]  rs1 = 5'd0;
    logic [4:0]  rs2 = 5'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [6:0]  funct7 = 7'd0;
    logic [31:0] imm = 32'd0;
    logic        clear = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        out_err;
    logic [7:0]  err_cnt;

    inst_encoder #(.BASE_ADDR(32'h0000_0000), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
        .imm(imm), .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          pop_cyc[$];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_addr = 32'h0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every handshake on the output pops one expected word.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got inst %h addr %h with empty scoreboard", out_inst, out_addr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_inst", out_inst, e.inst);
                check("out_addr", out_addr, e.addr);
                check("out_err", {31'd0, out_err}, {31'd0, e.err});
                pop_cyc.push_back(cyc);
            end
        end
    end

    task automatic send(input logic [2:0] a_fmt, input logic [4:0] a_rd, input logic [4:0] a_rs1,
                        input logic [4:0] a_rs2, input logic [2:0] a_f3, input logic [6:0] a_f7,
                        input logic [31:0] a_imm, input logic [31:0] a_inst, input logic a_err);
        bit done = 0;
        fmt = a_fmt; rd = a_rd; rs1 = a_rs1; rs2 = a_rs2;
        funct3 = a_f3; funct7 = a_f7; imm = a_imm;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{a_inst, exp_addr, a_err});
                exp_addr = exp_addr + 32'd4;
                done = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 20 cycles");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        int n0;
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_inst", out_inst, 32'h0);
        check("rst_out_addr", out_addr, 32'h0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic formats; S and B issued back to back must leave no bubble.
        send(3'd2, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0);
        n0 = pop_cyc.size() + 1;
        send(3'd3, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd8, 32'h0051_2423, 1'b0);
        send(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4, 32'hFE00_0EE3, 1'b0);
        drain();
        if (pop_cyc.size() >= n0 + 2)
            check("no_bubble", pop_cyc[n0+1] - pop_cyc[n0], 1);
        else
            check("no_bubble_pops", pop_cyc.size(), n0 + 2);

        send(3'd6, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h0080_00EF, 1'b0);
        send(3'd5, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'hDEAD_BEEF, 32'h0020_81B3, 1'b0);
        send(3'd1, 5'd6, 5'd2, 5'd0, 3'd2, 7'd0, -32'sd8, 32'hFF81_2303, 1'b0);
        send(3'd7, 5'd1, 5'd5, 5'd0, 3'd3, 7'd0, 32'd4, 32'h0042_80E7, 1'b0);
        send(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2048, 32'h8000_0023, 1'b0);
        send(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4096, 32'h8000_0063, 1'b0);
        drain();

        // Range errors and saturation of the error counter.
        send(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0000_0013, 1'b1);
        drain();
        check("err_cnt_1", {24'd0, err_cnt}, 32'd1);
        send(3'd2, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0000_0013, 1'b1);
        send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1001, 32'h0000_0013, 1'b1);
        send(3'd6, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, 32'h0000_0013, 1'b1);
        drain();
        check("err_cnt_4", {24'd0, err_cnt}, 32'd4);
        for (int i = 0; i < 300; i++)
            send(3'd2, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0000_0013, 1'b1);
        drain();
        check("err_cnt_sat", {24'd0, err_cnt}, 32'd255);

        // Backpressure: held word must stay put while the next one waits.
        out_ready = 1'b0;
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 32'h0020_81B3, 1'b0);
        fmt = 3'd0; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2; funct3 = 3'd0; funct7 = 7'h20;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_inst", out_inst, 32'h0020_81B3);
            check("bp_addr", out_addr, exp_addr - 32'd4);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0, 32'h4020_81B3, 1'b0);
        drain();

        // clear drops the held word and rewinds the address.
        out_ready = 1'b0;
        send(3'd1, 5'd6, 5'd2, 5'd0, 3'd2, 7'd0, -32'sd8, 32'hFF81_2303, 1'b0);
        fmt = 3'd7; rd = 5'd1; rs1 = 5'd5; imm = 32'd4; in_valid = 1'b1; clear = 1'b1;
        @(negedge clk);
        check("clr_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        void'(sb.pop_back());
        exp_addr = 32'h0;
        check("clr_out_valid", {31'd0, out_valid}, 32'd0);
        check("clr_err_cnt", {24'd0, err_cnt}, 32'd0);
        out_ready = 1'b1;
        send(3'd7, 5'd1, 5'd5, 5'd0, 3'd0, 7'd0, 32'd4, 32'h0042_80E7, 1'b0);
        drain();

        // Asynchronous reset mid-transfer.
        out_ready = 1'b0;
        send(3'd2, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0000_0013, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_out_inst", out_inst, 32'h0);
        check("arst_out_addr", out_addr, 32'h0);
        check("arst_err_cnt", {24'd0, err_cnt}, 32'd0);
        void'(sb.pop_back());
        exp_addr = 32'h0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2048, 32'h8000_0023, 1'b0);
        drain();

        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
